// File: rtl/mainfsm_stall_if.sv
// Control bundle between the instruction decoder and the main control FSM.
// master: decoder/memory side, drives the decode fields and MemReady.
// slave:  mainfsm_stall, drives the datapath controls and debug/perf outputs.
interface mainfsm_stall_if #(
    parameter int CNT_W = 32
);
    // Decode and memory handshake inputs to the FSM
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             Flag_64b;
    logic             MemReady;

    // Datapath controls
    logic             IRWrite;
    logic             AdrSrc;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             Branch;
    logic             ALUOp;
    logic             Src_64b;
    logic             FpuW;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;

    // Debug and performance outputs
    logic [3:0]       State;
    logic [CNT_W-1:0] RetireCnt;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output Op, Funct, Flag_64b, MemReady,
        input  IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Src_64b, FpuW,
        input  ALUSrcA, ALUSrcB, ResultSrc, State, RetireCnt, StallCnt
    );

    modport slave (
        input  Op, Funct, Flag_64b, MemReady,
        output IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Src_64b, FpuW,
        output ALUSrcA, ALUSrcB, ResultSrc, State, RetireCnt, StallCnt
    );
endinterface

// File: rtl/mainfsm_stall.sv
// Multicycle ARM main control FSM with memory ready stalls, multi-cycle FPU
// execute and optional two-cycle 64-bit writeback.
// Optional feature: define MAINFSM_PERF_EN to build the retire/stall counters;
// otherwise RetireCnt and StallCnt are tied to 0.
module mainfsm_stall #(
    parameter int FPU_LAT    = 4,
    parameter int WB64_SPLIT = 1,
    parameter int CNT_W      = 32
) (
    input  logic           clk,
    input  logic           reset,
    mainfsm_stall_if.slave bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_EXECUTEF = 4'd11;
    localparam logic [3:0] S_FPUWB    = 4'd12;
    localparam logic [3:0] S_ALUWB64  = 4'd13;

    localparam logic [3:0] FPU_LOAD = 4'(FPU_LAT - 1);
    localparam bit         SPLIT    = (WB64_SPLIT != 0);

    logic [3:0] state_reg, state_next;
    logic [3:0] fpu_cnt_reg;
    logic       wide_q_reg;

    // Funct[4:1] carry no control meaning here
    logic unused_funct;
    assign unused_funct = ^bus.Funct[4:1];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_FETCH;
        else       state_reg <= state_next;
    end

    // FPU latency down-counter and 64-bit result flag
    always_ff @(posedge clk) begin
        if (reset) begin
            fpu_cnt_reg <= 4'd0;
            wide_q_reg  <= 1'b0;
        end else begin
            if (state_reg == S_DECODE && state_next == S_EXECUTEF)
                fpu_cnt_reg <= FPU_LOAD;
            else if (state_reg == S_EXECUTEF && fpu_cnt_reg != 4'd0)
                fpu_cnt_reg <= fpu_cnt_reg - 4'd1;
            if (state_reg == S_EXECUTER || state_reg == S_EXECUTEI)
                wide_q_reg <= bus.Flag_64b;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    2'b00:   state_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_next = S_MEMADR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_EXECUTEF;
                endcase
            end
            S_MEMADR:   state_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_next = bus.MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_next = bus.MemReady ? S_FETCH : S_MEMWR;
            S_EXECUTER,
            S_EXECUTEI: state_next = (!SPLIT && bus.Flag_64b) ? S_ALUWB64 : S_ALUWB;
            S_ALUWB:    state_next = (SPLIT && wide_q_reg) ? S_ALUWB64 : S_FETCH;
            S_EXECUTEF: state_next = (fpu_cnt_reg == 4'd0) ? S_FPUWB : S_EXECUTEF;
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode from current state (and MemReady in FETCH)
    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.NextPC    = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.Branch    = 1'b0;
        bus.ALUOp     = 1'b0;
        bus.Src_64b   = 1'b0;
        bus.FpuW      = 1'b0;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.State     = state_reg;
        case (state_reg)
            S_FETCH: begin
                bus.IRWrite   = bus.MemReady;
                bus.NextPC    = bus.MemReady;
                bus.ResultSrc = 2'b10;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
            end
            S_DECODE: begin
                bus.ResultSrc = 2'b10;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
            end
            S_EXECUTER: bus.ALUOp = 1'b1;
            S_EXECUTEI: begin
                bus.ALUOp   = 1'b1;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMADR: bus.ALUSrcB = 2'b01;
            S_MEMRD:  bus.AdrSrc  = 1'b1;
            S_MEMWR: begin
                bus.AdrSrc = 1'b1;
                bus.MemW   = 1'b1;
            end
            S_MEMWB: begin
                bus.RegW      = 1'b1;
                bus.ResultSrc = 2'b01;
            end
            S_ALUWB:   bus.RegW = 1'b1;
            S_ALUWB64: begin
                bus.RegW    = 1'b1;
                bus.Src_64b = 1'b1;
            end
            S_BRANCH: begin
                bus.Branch    = 1'b1;
                bus.ResultSrc = 2'b10;
                bus.ALUSrcB   = 2'b01;
            end
            S_FPUWB: bus.FpuW = 1'b1;
            default: ;
        endcase
    end

`ifdef MAINFSM_PERF_EN
    logic [CNT_W-1:0] retire_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             retire_evt;
    logic             stall_evt;

    // An instruction retires when a final state hands back to FETCH
    always_comb begin
        retire_evt = 1'b0;
        if (state_next == S_FETCH) begin
            case (state_reg)
                S_MEMWB, S_MEMWR, S_ALUWB, S_ALUWB64, S_FPUWB, S_BRANCH: retire_evt = 1'b1;
                default: retire_evt = 1'b0;
            endcase
        end
        stall_evt = !bus.MemReady &&
                    (state_reg == S_FETCH || state_reg == S_MEMRD || state_reg == S_MEMWR);
    end

    // Free-running counters, wrapping at 2^CNT_W
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            if (retire_evt) retire_cnt_reg <= retire_cnt_reg + 1'b1;
            if (stall_evt)  stall_cnt_reg  <= stall_cnt_reg + 1'b1;
        end
    end

    assign bus.RetireCnt = retire_cnt_reg;
    assign bus.StallCnt  = stall_cnt_reg;
`else
    assign bus.RetireCnt = '0;
    assign bus.StallCnt  = '0;
`endif
endmodule
